// File: rtl/prog_launcher.sv
// Launch sequencer: copies the program image into core data memory,
// pulses the core's init, then times the run until done or timeout.
module prog_launcher #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] src_addr,
    input  logic [DW-1:0] src_rdata,
    output logic          dm_we,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          core_init,
    input  logic          core_done,
    output logic [1:0]    prog_id,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [15:0]   cycles
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        LAUNCH,
        RUN,
        FINISH
    } state_t;

    localparam logic [AW-1:0] A_FIRST = AW'(1);
    localparam logic [AW-1:0] A_LAST  = AW'(147);
    localparam logic [15:0]   TO_LAST = 16'(TIMEOUT - 1);

    state_t state;
    state_t nxt;

    logic last_addr;
    logic run_hit;
    logic run_tmo;

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        logic [AW-1:0] n;
        unique case (1'b1)
            a == AW'(3):  n = AW'(6);
            a == AW'(6):  n = AW'(32);
            a == AW'(95): n = AW'(128);
            default:      n = a + AW'(1);
        endcase
        return n;
    endfunction

    assign last_addr = (src_addr == A_LAST);

    // A stale done from the previous run is masked while cycles is still 0.
    assign run_hit = (state == RUN) && (cycles != 16'd0) && core_done;
    assign run_tmo = (state == RUN) && !run_hit && (cycles == TO_LAST);

    // Write data passes the image read straight through while writing.
    assign dm_wdata = dm_we ? src_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = LOAD;
            LOAD:    if (last_addr) nxt = DRAIN;
            DRAIN:   nxt = LAUNCH;
            LAUNCH:  nxt = RUN;
            RUN:     if (run_hit || run_tmo) nxt = FINISH;
            FINISH:  nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_addr  <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            core_init <= 1'b0;
            prog_id   <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= 16'd0;
        end else begin
            dm_we <= (state == LOAD);
            done  <= (nxt == FINISH);
            if (state == LOAD) begin
                dm_addr <= src_addr;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        src_addr  <= A_FIRST;
                        busy      <= 1'b1;
                        core_init <= 1'b1;
                        cycles    <= 16'd0;
                        timeout   <= 1'b0;
                        if (prog_id == 2'd3 || prog_id == 2'd0) begin
                            prog_id <= 2'd1;
                        end else begin
                            prog_id <= prog_id + 2'd1;
                        end
                    end
                end
                LOAD: begin
                    if (!last_addr) begin
                        src_addr <= next_addr(src_addr);
                    end
                end
                DRAIN: begin
                    core_init <= 1'b0;
                end
                RUN: begin
                    if (!run_tmo && cycles != 16'hFFFF) begin
                        cycles <= cycles + 16'd1;
                    end
                    if (run_tmo) begin
                        timeout <= 1'b1;
                    end
                    if (run_hit || run_tmo) begin
                        busy <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_launcher.sv
// Directed bench for prog_launcher: load image, run timing,
// program rotation, timeout, stale done and mid-load reset.
module tb_prog_launcher;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  src_addr;
    logic [7:0]  src_rdata;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic        core_init;
    logic        core_done;
    logic [1:0]  prog_id;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] cycles;

    int nchecks = 0;
    int nfail   = 0;

    logic en;
    logic stuck;
    int   cnt = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    logic [7:0] exp_a[88];
    logic [46:0] outs;

    prog_launcher #(.AW(8), .DW(8), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .src_addr  (src_addr),
        .src_rdata (src_rdata),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .core_init (core_init),
        .core_done (core_done),
        .prog_id   (prog_id),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] img(input logic [7:0] a);
        return (a * 8'd37) ^ 8'h5C;
    endfunction

    always @(posedge clk) src_rdata <= img(src_addr);

    // Core model: done rises 10 cycles after init falls.
    always @(posedge clk) begin
        if (core_init) cnt <= 0;
        else if (cnt < 1000) cnt <= cnt + 1;
    end
    assign core_done = stuck | (en & (cnt >= 10));

    always @(negedge clk) begin
        if (dm_we) begin
            wa.push_back(dm_addr);
            wd.push_back(dm_wdata);
        end
    end

    assign outs = {src_addr, dm_we, dm_addr, dm_wdata, core_init,
                   prog_id, busy, done, timeout, cycles};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int pulse_at, output int lat,
                             output int ci_cnt, output int ci_last);
        lat = 1;
        ci_cnt = 0;
        ci_last = 0;
        while (!done && lat < 400) begin
            if (core_init) begin
                ci_cnt++;
                ci_last = lat;
            end
            if (pulse_at > 0) start = (lat == pulse_at);
            tick();
            lat++;
        end
        if (pulse_at > 0) start = 1'b0;
        chk("done_seen", done, 1);
    endtask

    task automatic check_writes(input string tag);
        int bad;
        int first;
        bad = 0;
        first = -1;
        chk({tag, "_count"}, wa.size(), 88);
        for (int i = 0; i < 88 && i < wa.size(); i++) begin
            if (wa[i] !== exp_a[i] || wd[i] !== img(exp_a[i])) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        if (first >= 0)
            $display("first bad write %0d: addr %0h data %0h",
                     first, wa[first], wd[first]);
        chk({tag, "_bad"}, bad, 0);
    endtask

    initial begin
        int lat;
        int ci_cnt;
        int ci_last;
        int n;
        int k;
        logic [1:0] exp_id[3];

        k = 0;
        for (int a = 1; a <= 3; a++) begin exp_a[k] = 8'(a); k++; end
        exp_a[k] = 8'd6; k++;
        for (int a = 32; a <= 95; a++) begin exp_a[k] = 8'(a); k++; end
        for (int a = 128; a <= 147; a++) begin exp_a[k] = 8'(a); k++; end
        exp_id[0] = 2'd2;
        exp_id[1] = 2'd3;
        exp_id[2] = 2'd1;

        rst_n = 1'b0;
        start = 1'b0;
        en    = 1'b1;
        stuck = 1'b0;
        #3;
        chk("reset_outs", outs, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick();
        tick();

        wa.delete();
        wd.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c1_src_addr", src_addr, 1);
        chk("c1_core_init", core_init, 1);
        chk("c1_busy", busy, 1);
        chk("c1_prog_id", prog_id, 1);
        chk("c1_dm_we", dm_we, 0);
        wait_done(0, lat, ci_cnt, ci_last);
        chk("run1_latency", lat, 101);
        chk("run1_init_cycles", ci_cnt, 89);
        chk("run1_init_last", ci_last, 89);
        chk("run1_cycles", cycles, 10);
        chk("run1_timeout", timeout, 0);
        chk("run1_busy", busy, 0);
        check_writes("load1");
        tick();
        chk("run1_done_pulse", done, 0);

        start = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("b2b_prog_id", prog_id, exp_id[r]);
            chk("b2b_busy", busy, 1);
            wait_done(0, lat, ci_cnt, ci_last);
            chk("b2b_latency", lat, 101);
            chk("b2b_done_busy", busy, 0);
            tick();
            chk("b2b_idle_done", done, 0);
            chk("b2b_idle_busy", busy, 0);
        end
        start = 1'b0;

        en = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("tmo_prog_id", prog_id, 2);
        wait_done(0, lat, ci_cnt, ci_last);
        chk("tmo_latency", lat, 155);
        chk("tmo_flag", timeout, 1);
        chk("tmo_cycles", cycles, 63);
        tick();
        chk("tmo_hold", timeout, 1);
        chk("tmo_done_pulse", done, 0);

        stuck = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("stale_tmo_clr", timeout, 0);
        chk("stale_prog_id", prog_id, 3);
        chk("stale_cycles0", cycles, 0);
        wait_done(0, lat, ci_cnt, ci_last);
        chk("stale_latency", lat, 93);
        chk("stale_cycles", cycles, 2);
        chk("stale_timeout", timeout, 0);
        stuck = 1'b0;
        en = 1'b1;
        tick();

        wa.delete();
        wd.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (src_addr !== 8'd40 && n < 50) begin
            tick();
            n++;
        end
        chk("rst_reach40", src_addr, 40);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_outs", outs, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (4) tick();
        chk("rst_no_writes", wa.size(), 11);
        chk("rst_busy", busy, 0);
        chk("rst_prog_id", prog_id, 0);

        wa.delete();
        wd.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_prog_id", prog_id, 1);
        wait_done(95, lat, ci_cnt, ci_last);
        chk("post_rst_latency", lat, 101);
        check_writes("load2");
        repeat (3) tick();
        chk("ignored_start_busy", busy, 0);
        chk("ignored_start_id", prog_id, 1);

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule

// File: doc/prog_launcher.md
# prog_launcher

Synthesizable launch sequencer that sits directly upstream of the `top` core. On each `start` it copies the fixed program-image address set from a source image memory into the core's data memory. It then holds and releases the core's `init` and waits for the core's `done`. It rotates a program index 1→2→3→1 across runs and reports completion, timeout and the run's cycle count.

## Interface
Parameters:
- `AW`, 8, address width of source image and data memory
- `DW`, 8, data width
- `TIMEOUT`, 4096, maximum RUN cycles before abort

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request one program run; sampled only in IDLE
- `src_addr`  out  AW  source image read address
- `src_rdata`  in  DW  source image read data, valid one cycle after `src_addr`
- `dm_we`  out  1  data-memory write enable
- `dm_addr`  out  AW  data-memory write address
- `dm_wdata`  out  DW  data-memory write data
- `core_init`  out  1  to core `init`; high during load, falling edge launches core
- `core_done`  in  1  from core `done`
- `prog_id`  out  2  current program index, 0 before first run, then 1..3
- `busy`  out  1  high from accepted `start` until FINISH
- `done`  out  1  one-cycle completion pulse
- `timeout`  out  1  set when run aborted by timeout; cleared on next accepted `start`
- `cycles`  out  16  RUN cycles of the last or current run, saturating at 16'hFFFF

## Operation
- States: IDLE, LOAD, DRAIN, LAUNCH, RUN, FINISH.
- Load address set, in order, 88 words total:
  - 1, 2, 3
  - 6
  - 32..95
  - 128..147
- Next-address rule:
  - 3→6
  - 6→32
  - 95→128
  - 147→end of list
  - otherwise +1
- IDLE with `start`=1:
  - →LOAD.
  - `src_addr`←1; `busy`←1; `core_init`←1.
  - `cycles`←0; `timeout`←0.
  - `prog_id`←(`prog_id`==3 or 0) ? 1 : `prog_id`+1.
- LOAD:
  - Each cycle `src_addr` advances per the list.
  - Write pipeline: `dm_we`, `dm_addr`, `dm_wdata` are registered one cycle behind the read. `dm_addr` is the previous `src_addr` and `dm_wdata` is `src_rdata`.
  - After address 147 is presented: →DRAIN.
- DRAIN: final write (addr 147) is issued; →LAUNCH.
- LAUNCH:
  - `dm_we`←0; `core_init`←0 (falling edge starts core).
  - →RUN.
- RUN:
  - `cycles` increments each cycle, saturating.
  - `core_done` is ignored in the first RUN cycle, because `done` may be stale from the previous run.
  - From the second RUN cycle on, `core_done`=1 →FINISH.
  - If `cycles` reaches TIMEOUT-1 without `core_done`: `timeout`←1, →FINISH.
- FINISH:
  - `done`=1 for exactly one cycle.
  - `busy`←0.
  - →IDLE.
- `start` outside IDLE is ignored, with no queuing.
- `src_addr` holds its last value outside LOAD.
- `dm_we` is 0 outside the write pipeline.

## Timing
- Reset values: every output is 0, i.e. `src_addr`, `dm_we`, `dm_addr`, `dm_wdata`, `core_init`, `prog_id`, `busy`, `done`, `timeout`, `cycles`. State is IDLE.
- Edge E0 samples `start`. The cycle after E0 shows:
  - `src_addr`=1
  - `core_init`=1
  - `busy`=1
- Reads occupy 88 consecutive cycles (cycles 1..88). Writes occupy cycles 2..89, one per cycle, no gaps.
- DRAIN is cycle 89, LAUNCH is cycle 90 (`core_init` falls), RUN begins cycle 91.
- `done` is asserted the cycle after `core_done` is sampled in RUN. Minimum E0→`done` is 93 cycles.
- `busy` falls in the same cycle `done` rises. A `start` held continuously is accepted again on the first IDLE cycle, so `done` and a new `busy` are never asserted together.
- Asynchronous reset mid-operation:
  - Outputs return to reset values immediately.
  - `core_init` drops to 0.
  - `prog_id` returns to 0, so the next run is program 1.
  - Any partial load is abandoned; no further writes occur.

## Test plan
- Reset then single `start`:
  - `dm_we` writes addresses 1,2,3,6,32..95,128..147 with data equal to source image contents; exactly 88 writes.
  - `core_init` high cycles 1..89.
  - `prog_id`=1.
- Core model asserts `core_done` 10 cycles after `init` falls: `done` pulses once, `cycles`=10, `timeout`=0, `busy`=0.
- Four back-to-back runs: `prog_id` sequence is 1,2,3,1.
- Core never asserts done with TIMEOUT=64: `done` at RUN cycle 64, `timeout`=1, `cycles`=63. The next `start` clears `timeout`.
- `core_done` stuck high from the previous run:
  - It is ignored in the first RUN cycle.
  - FINISH occurs on the second RUN cycle.
  - `cycles`=2.
- `rst_n` pulsed low during LOAD at address 40:
  - All outputs are 0 immediately and no further writes occur.
  - A subsequent `start` performs a full 88-write load with `prog_id`=1.
  - `start` pulses during RUN are ignored.
